// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: opcodes, instruction
// layouts, FSM state and error encodings, and the word-alignment check.
package lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [2:0] F3_LW     = 3'b010;
  localparam logic [2:0] F3_SW     = 3'b010;

  typedef struct packed {
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } i_type_t;

  typedef struct packed {
    logic [6:0] imm_11_5;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] imm_4_0;
    logic [6:0] opcode;
  } s_type_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } lsu_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } lsu_err_t;

  // Only full-word accesses exist, so any nonzero low address bit is a fault.
  function automatic logic addr_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_addr_gen.sv
// Combinational LW/SW decode, effective-address generation and alignment check.
module lsu_addr_gen
  import lsu_pkg::*;
(
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_val,
  output logic            is_load,
  output logic            is_store,
  output logic            illegal,
  output logic [XLEN-1:0] addr,
  output logic            misaligned
);

  i_type_t         ld_fmt;
  s_type_t         st_fmt;
  logic [XLEN-1:0] imm_ext;

  assign ld_fmt = i_type_t'(instr);
  assign st_fmt = s_type_t'(instr);

  assign is_load  = (ld_fmt.opcode == OPC_LOAD)  && (ld_fmt.funct3 == F3_LW);
  assign is_store = (st_fmt.opcode == OPC_STORE) && (st_fmt.funct3 == F3_SW);
  assign illegal  = !(is_load || is_store);

  // Stores split the immediate around the rd slot; loads keep it contiguous.
  always_comb begin
    imm_ext = {{20{ld_fmt.imm[11]}}, ld_fmt.imm};
    if (is_store) begin
      imm_ext = {{20{st_fmt.imm_11_5[6]}}, st_fmt.imm_11_5, st_fmt.imm_4_0};
    end
  end

  assign addr       = rs1_val + imm_ext;
  assign misaligned = addr_misaligned(addr[1:0]);

endmodule

// File: rtl/lsu_mem_ctrl.sv
// LW/SW sequencing controller: one outstanding request/grant/response bus
// transaction. Define LSU_TIMEOUT_EN to enable the REQ/WAIT bus watchdog.
module lsu_mem_ctrl #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_wb,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_data,
  output logic            out_err,
  output logic [1:0]      out_err_code
);

  import lsu_pkg::*;

  lsu_state_t      state_reg, state_next;
  logic [XLEN-1:0] addr_reg, wdata_reg, data_reg;
  logic            we_reg, wb_reg;
  logic [4:0]      rd_reg;
  lsu_err_t        err_reg;

  logic            dec_load, dec_store, dec_illegal, dec_misaligned;
  logic [XLEN-1:0] dec_addr;
  logic            timeout_hit;
  logic            req_active, resp_active;

  lsu_addr_gen u_addr_gen (
    .instr      (in_instr),
    .rs1_val    (in_rs1_val),
    .is_load    (dec_load),
    .is_store   (dec_store),
    .illegal    (dec_illegal),
    .addr       (dec_addr),
    .misaligned (dec_misaligned)
  );

`ifdef LSU_TIMEOUT_EN
  logic [7:0] timer_reg;

  // Held at zero in IDLE so it restarts on every entry into REQ.
  always_ff @(posedge clk) begin
    if (rst || state_reg == ST_IDLE) begin
      timer_reg <= 8'd0;
    end else if (state_reg == ST_REQ || state_reg == ST_WAIT) begin
      timer_reg <= timer_reg + 8'd1;
    end
  end

  assign timeout_hit = (state_reg == ST_REQ || state_reg == ST_WAIT) &&
                       (timer_reg == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A grant or rvalid arriving in the watchdog's final cycle still completes.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          state_next = (dec_illegal || dec_misaligned) ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          state_next = we_reg ? ST_RESP : ST_WAIT;
        end else if (timeout_hit) begin
          state_next = ST_RESP;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid || timeout_hit) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      data_reg  <= '0;
      we_reg    <= 1'b0;
      wb_reg    <= 1'b0;
      rd_reg    <= 5'd0;
      err_reg   <= ERR_NONE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            addr_reg  <= dec_addr;
            wdata_reg <= in_rs2_val;
            data_reg  <= '0;
            we_reg    <= dec_store;
            wb_reg    <= 1'b0;
            rd_reg    <= dec_load ? in_instr[11:7] : 5'd0;
            if (dec_illegal) begin
              err_reg <= ERR_ILLEGAL;
            end else if (dec_misaligned) begin
              err_reg <= ERR_MISALIGN;
            end else begin
              err_reg <= ERR_NONE;
            end
          end
        end
        ST_REQ: begin
          if (!mem_gnt && timeout_hit) begin
            err_reg <= ERR_TIMEOUT;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            data_reg <= mem_rdata;
            wb_reg   <= (rd_reg != 5'd0);
          end else if (timeout_hit) begin
            err_reg <= ERR_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are forced low while rst is asserted, regardless of prior state.
  assign req_active  = !rst && (state_reg == ST_REQ);
  assign resp_active = !rst && (state_reg == ST_RESP);

  assign in_ready  = !rst && (state_reg == ST_IDLE);

  assign mem_req   = req_active;
  assign mem_we    = req_active && we_reg;
  assign mem_addr  = req_active ? addr_reg  : '0;
  assign mem_wdata = req_active ? wdata_reg : '0;
  assign mem_be    = req_active ? 4'b1111   : 4'b0000;

  assign out_valid    = resp_active;
  assign out_wb       = resp_active && wb_reg;
  assign out_rd       = resp_active ? rd_reg   : 5'd0;
  assign out_data     = resp_active ? data_reg : '0;
  assign out_err      = resp_active && (err_reg != ERR_NONE);
  assign out_err_code = resp_active ? err_reg  : ERR_NONE;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Table-driven bench for lsu_mem_ctrl with a result scoreboard and a few
// hand-written reset / timeout sequences.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr, in_rs1_val, in_rs2_val;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid, out_ready, out_wb, out_err;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic [1:0]  out_err_code;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_wb(out_wb),
    .out_rd(out_rd), .out_data(out_data), .out_err(out_err),
    .out_err_code(out_err_code)
  );

  typedef struct {
    logic [31:0] instr, rs1, rs2, rdata;
    int          gnt_dly, hold;
    bit          stray, bus;
    logic [31:0] exp_addr;
    bit          exp_we, exp_wb;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    logic [1:0]  exp_code;
    int          exp_lat;
  } vec_t;

  typedef struct {
    bit          wb;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  code;
  } res_t;

  res_t sb[$];
  vec_t vecs[10];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Called at #1 in a cycle where the DUT should be IDLE; returns at #1 of
  // the cycle after the result was consumed.
  task automatic run_txn(input vec_t v, input string tag);
    int   cyc, req_n, resp_n;
    bit   rv_pend, done;
    res_t exp_r;
    check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid   = 1'b1;
    in_instr   = v.instr;
    in_rs1_val = v.rs1;
    in_rs2_val = v.rs2;
    exp_r = '{wb: v.exp_wb, rd: v.exp_rd, data: v.exp_data, code: v.exp_code};
    sb.push_back(exp_r);
    @(posedge clk); #1;
    in_valid   = 1'b0;
    in_instr   = $urandom;
    in_rs1_val = $urandom;
    in_rs2_val = $urandom;
    cyc = 1; req_n = 0; resp_n = 0; rv_pend = 1'b0; done = 1'b0;
    while (!done) begin
      if (cyc > 200) begin
        check({tag, ".cycle_budget"}, cyc, v.exp_lat);
        void'(sb.pop_front());
        break;
      end
      mem_gnt    = 1'b0;
      mem_rvalid = rv_pend;
      mem_rdata  = rv_pend ? v.rdata : 32'hBAD0BAD0;
      rv_pend    = 1'b0;
      if (mem_req) begin
        req_n++;
        if (!v.bus) begin
          if (req_n == 1) check({tag, ".no_bus"}, {31'd0, mem_req}, 32'd0);
        end else begin
          check({tag, ".addr"}, mem_addr, v.exp_addr);
          check({tag, ".we"}, {31'd0, mem_we}, {31'd0, v.exp_we});
          check({tag, ".be"}, {28'd0, mem_be}, 32'hF);
          if (v.exp_we) check({tag, ".wdata"}, mem_wdata, v.rs2);
        end
        if (req_n > v.gnt_dly) begin
          mem_gnt = 1'b1;
          rv_pend = !v.exp_we;
        end else if (v.stray) begin
          mem_rvalid = 1'b1;
        end
      end
      if (out_valid) begin
        if (resp_n == 0) begin
          check({tag, ".latency"}, cyc, v.exp_lat);
          check({tag, ".req_cycles"}, req_n, v.bus ? v.gnt_dly + 1 : 0);
          if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
          end else begin
            exp_r = sb.pop_front();
          end
        end
        check({tag, ".wb"}, {31'd0, out_wb}, {31'd0, exp_r.wb});
        check({tag, ".rd"}, {27'd0, out_rd}, {27'd0, exp_r.rd});
        check({tag, ".data"}, out_data, exp_r.data);
        check({tag, ".err"}, {31'd0, out_err}, {31'd0, exp_r.code != 2'b00});
        check({tag, ".code"}, {30'd0, out_err_code}, {30'd0, exp_r.code});
        check({tag, ".in_ready_resp"}, {31'd0, in_ready}, 32'd0);
        resp_n++;
        out_ready = (resp_n > v.hold);
        if (out_ready) done = 1'b1;
      end else begin
        out_ready = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready  = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    $display("txn %s: instr=0x%08h done after %0d cycles", tag, v.instr, cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog: got timeout, want $finish");
    $fatal(1, "simulation hung");
  end

  initial begin
    int n;
    vec_t lw_fresh;
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_rs1_val = '0; in_rs2_val = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; out_ready = 1'b0;

    //                 instr         rs1           rs2           rdata        dly hold stray bus addr        we wb rd  data          code lat
    vecs[0] = '{32'h0080A283, 32'h00001000, 32'h0,        32'hDEADBEEF, 0, 0, 0, 1, 32'h00001008, 0, 1, 5'd5,  32'hDEADBEEF, 2'b00, 3};
    vecs[1] = '{32'hFE21AE23, 32'h00002000, 32'h12345678, 32'h0,        3, 0, 0, 1, 32'h00001FFC, 1, 0, 5'd0,  32'h0,        2'b00, 5};
    vecs[2] = '{32'h00002383, 32'h00001002, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        0, 0, 5'd7,  32'h0,        2'b01, 1};
    vecs[3] = '{32'h00000013, 32'h00000000, 32'h0,        32'h0,        0, 4, 0, 0, 32'h0,        0, 0, 5'd0,  32'h0,        2'b11, 1};
    vecs[4] = '{32'h0000A003, 32'h00000040, 32'h0,        32'hAAAA5555, 2, 0, 1, 1, 32'h00000040, 0, 0, 5'd0,  32'hAAAA5555, 2'b00, 5};
    vecs[5] = '{32'h00532123, 32'h00000100, 32'h55555555, 32'h0,        0, 0, 0, 0, 32'h0,        0, 0, 5'd0,  32'h0,        2'b01, 1};
    vecs[6] = '{32'h00008283, 32'h00001000, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        0, 0, 5'd0,  32'h0,        2'b11, 1};
    vecs[7] = '{32'hFFC12503, 32'h00000000, 32'h0,        32'h0BADF00D, 0, 2, 0, 1, 32'hFFFFFFFC, 0, 1, 5'd10, 32'h0BADF00D, 2'b00, 3};
    vecs[8] = '{32'h7E922FA3, 32'h00000001, 32'hCAFEF00D, 32'h0,        0, 0, 0, 1, 32'h00000800, 1, 0, 5'd0,  32'h0,        2'b00, 2};
    vecs[9] = '{32'h00530023, 32'h00000100, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        0, 0, 5'd0,  32'h0,        2'b11, 1};

    // Reset state: offered instructions are ignored and every output is low.
    in_valid = 1'b1; in_instr = 32'h0080A283;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst.in_ready", {31'd0, in_ready}, 32'd0);
      check("rst.mem_req", {31'd0, mem_req}, 32'd0);
      check("rst.out_valid", {31'd0, out_valid}, 32'd0);
      check("rst.mem_addr", mem_addr, 32'd0);
      check("rst.out_code", {30'd0, out_err_code}, 32'd0);
    end
    in_valid = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    check("rst.in_ready_after", {31'd0, in_ready}, 32'd1);
    check("rst.out_valid_after", {31'd0, out_valid}, 32'd0);
    $display("seq reset: released");

    // Table vectors, issued back to back.
    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while a load sits in WAIT: result discarded, stray rvalid ignored.
    in_valid = 1'b1; in_instr = 32'h0080A283; in_rs1_val = 32'h00003000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rstwait.req", {31'd0, mem_req}, 32'd1);
    check("rstwait.addr", mem_addr, 32'h00003008);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    check("rstwait.req_drop", {31'd0, mem_req}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h99999999;
    check("rstwait.req_after", {31'd0, mem_req}, 32'd0);
    check("rstwait.valid_after", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    check("rstwait.valid_late", {31'd0, out_valid}, 32'd0);
    check("rstwait.in_ready", {31'd0, in_ready}, 32'd1);
    $display("seq reset_in_wait: done");
    lw_fresh = vecs[0];
    lw_fresh.rdata = 32'h13579BDF; lw_fresh.exp_data = 32'h13579BDF;
    run_txn(lw_fresh, "fresh_lw");

`ifdef LSU_TIMEOUT_EN
    // Grant never arrives: 16 request cycles, then a timeout result.
    in_valid = 1'b1; in_instr = 32'hFE21AE23; in_rs1_val = 32'h00002000; in_rs2_val = 32'h0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    check("tmo.req_cycles", n, 16);
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'h77777777;
      check("tmo.valid", {31'd0, out_valid}, 32'd1);
      check("tmo.code", {30'd0, out_err_code}, 32'd2);
      check("tmo.err", {31'd0, out_err}, 32'd1);
      check("tmo.data", out_data, 32'd0);
      check("tmo.wb", {31'd0, out_wb}, 32'd0);
      check("tmo.req", {31'd0, mem_req}, 32'd0);
      out_ready = (i == 2);
      @(posedge clk); #1;
    end
    out_ready = 1'b0; mem_rvalid = 1'b0; mem_gnt = 1'b0;
    check("tmo.in_ready", {31'd0, in_ready}, 32'd1);
    $display("seq timeout: %0d request cycles", n);
`else
    // Without the watchdog a long stall still completes normally.
    lw_fresh = vecs[8];
    lw_fresh.gnt_dly = 30; lw_fresh.exp_lat = 32;
    run_txn(lw_fresh, "long_stall");
    n = 0;
`endif

    check("final.in_ready", {31'd0, in_ready}, 32'd1);
    check("final.sb_size", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store sequencing controller between the RV32 execute stage and the data-memory port. Accepts one decoded LW/SW instruction at a time with its operand values, computes and checks the effective address, drives a request/grant/response memory handshake, and returns a writeback or error result. Single outstanding transaction; sits directly in front of the data-memory bus agent.

## Interface
- XLEN, 32, data/address width; only 32 supported.
- TIMEOUT_CYCLES, 16, bus watchdog limit in cycles; range 2..255. Used only when LSU_TIMEOUT_EN is defined.

- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset; synchronous and active-high.
- in_valid  in  1  instruction offered.
- in_ready  out  1  controller can accept; high only in IDLE.
- in_instr  in  32  raw instruction word.
- in_rs1_val  in  XLEN  base register value.
- in_rs2_val  in  XLEN  store data.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = store.
- mem_addr  out  XLEN  word-aligned effective address.
- mem_wdata  out  XLEN  store data.
- mem_be  out  4  byte enables; 4'b1111 for every issued request.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  XLEN  load data.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_wb  out  1  write out_data to out_rd (successful load only).
- out_rd  out  5  destination register.
- out_data  out  XLEN  load data; 0 for stores and errors.
- out_err  out  1  transaction failed.
- out_err_code  out  2  00 none, 01 misaligned, 10 timeout, 11 illegal instruction.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: in_ready=1. On in_valid, register instruction fields, operands, and effective address = in_rs1_val + sign-extended 12-bit immediate, modulo 2^32. Immediate is I-type for loads and S-type ({imm_11_5, imm_4_0}) for stores.
- Decode: opcode 0000011 with funct3 010 is LW; opcode 0100011 with funct3 010 is SW. Anything else goes to RESP with err 11; no bus access.
- Address check: addr[1:0] != 0 goes to RESP with err 01; no bus access.
- Otherwise go to REQ.
- REQ: mem_req=1; addr/we/wdata/be stay stable until mem_gnt. On gnt, a store goes to RESP (success, out_wb=0) and a load goes to WAIT.
- WAIT: on mem_rvalid, capture mem_rdata and go to RESP with out_wb=1.
- mem_rvalid is honoured only in WAIT. It arrives at least one cycle after gnt. Any rvalid seen in other states is ignored.
- RESP: out_valid=1 and all out_* held stable until out_ready, then go to IDLE. in_ready stays 0 until IDLE.
- out_rd = instruction rd field for loads, 0 otherwise.
- Loads with rd = x0 still complete on the bus; out_wb=0.

## Timing
- Reset values: in_ready=0 during reset, then 1 the cycle after rst deasserts. All other outputs are 0 during reset. State goes to IDLE and the watchdog clears.
- Reset mid-transaction: mem_req drops on the next edge and the pending result is discarded.
- Accept at edge N. mem_req is high in cycle N+1.
- Store with immediate gnt: out_valid at N+2.
- Load with gnt at N+1 and rvalid at N+2: out_valid at N+3.
- Misaligned or illegal: out_valid at N+1.
- Back-to-back: if out_ready is high in the first RESP cycle, the next instruction can be accepted one cycle later (IDLE).
- mem_req falls in the cycle after gnt.

## Configuration
- LSU_TIMEOUT_EN defined: an 8-bit counter runs while in REQ or WAIT and clears on state entry from IDLE. When the count reaches TIMEOUT_CYCLES, go to RESP with err 10 and deassert mem_req. A late gnt or rvalid after that point is ignored.
- LSU_TIMEOUT_EN undefined: no counter; the controller waits indefinitely and err code 10 is never produced.

## Structure
- Shared package holds: the LOAD/STORE opcodes, LW/SW funct3, XLEN, the I-type and S-type instruction structs, the alignment-check function, and new additions lsu_state_t and lsu_err_t (2-bit enum).
- One sub-module, lsu_addr_gen: combinational decode plus effective-address generation and alignment check. Outputs: is_load, is_store, illegal, addr, misaligned.

## Test plan
- LW x5, 8(x1) with rs1=0x1000; gnt at N+1, rvalid at N+2 with rdata 0xDEADBEEF -> mem_addr=0x1008, we=0; out_valid at N+3, wb=1, rd=5, data=0xDEADBEEF.
- SW x2, -4(x3) with rs1=0x2000, rs2=0x12345678; gnt delayed 3 cycles -> addr=0x1FFC, we=1, wdata held stable through the stall; out_valid with wb=0, err=0.
- LW with rs1=0x1002, imm=0 -> no mem_req ever; out_valid at N+1, err=1, code 01.
- Instruction 0x00000013 (ADDI) -> err code 11, no bus activity. With out_ready low for 4 cycles, outputs stay stable.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=16, gnt never arrives -> mem_req drops and err code 10 after 16 REQ cycles; a stray rvalid afterwards is ignored.
- rst asserted in WAIT -> next cycle mem_req=0 and out_valid=0; a following fresh LW completes normally.
